// File: rtl/pic_icsp_loader_pkg.sv
// Shared types and constants for the ICSP program loader.
// Command codes, frame sizes and the loader FSM state type.
package pic_icsp_pkg;

    localparam int CMD_BITS   = 6;
    localparam int FRAME_BITS = 16;
    localparam int WORD_W     = 14;

    localparam logic [CMD_BITS-1:0] CMD_LOAD = 6'h02;
    localparam logic [CMD_BITS-1:0] CMD_READ = 6'h04;
    localparam logic [CMD_BITS-1:0] CMD_INC  = 6'h06;
    localparam logic [CMD_BITS-1:0] CMD_PROG = 6'h08;
    localparam logic [CMD_BITS-1:0] CMD_RSTA = 6'h0B;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX,
        TX,
        WR
    } icsp_state_t;

endpackage

// File: rtl/pic_icsp_loader_if.sv
// Program-memory bus between the loader (master) and progmem (slave).
// Read data is combinational from addr on the memory side.
interface pic_icsp_loader_if #(
    parameter int ADDR_W = 11
);
    import pic_icsp_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              we;
    logic [WORD_W-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/pic_icsp_loader_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with registered
// single-cycle rise/fall pulses derived from the synchronised level.
module pic_icsp_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    assign q = sync;

endmodule

// File: rtl/pic_icsp_loader.sv
// ICSP-style serial loader: decodes 6-bit commands from the host and
// writes/reads 14-bit program words while holding the core in reset.
module pic_icsp_loader
    import pic_icsp_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int RELEASE_CYC = 4
) (
    input  logic clk,
    input  logic rst_ext,
    input  logic prog_en,
    input  logic icsp_clk,
    input  logic icsp_data_in,
    output logic icsp_data_out,
    output logic icsp_data_oe,
    output logic core_rst,
    pic_icsp_loader_if.master mem
);

    localparam int REL_W = $clog2(RELEASE_CYC + 2);

    logic pe_sync, pe_rise, pe_fall_unused;
    logic ck_level_unused, ck_rise, ck_fall;
    logic data_sync, data_rise_unused, data_fall_unused;

    pic_icsp_sync_edge u_sync_pe (
        .clk  (clk),
        .rst  (rst_ext),
        .d    (prog_en),
        .q    (pe_sync),
        .rise (pe_rise),
        .fall (pe_fall_unused)
    );

    pic_icsp_sync_edge u_sync_ck (
        .clk  (clk),
        .rst  (rst_ext),
        .d    (icsp_clk),
        .q    (ck_level_unused),
        .rise (ck_rise),
        .fall (ck_fall)
    );

    pic_icsp_sync_edge u_sync_data (
        .clk  (clk),
        .rst  (rst_ext),
        .d    (icsp_data_in),
        .q    (data_sync),
        .rise (data_rise_unused),
        .fall (data_fall_unused)
    );

    icsp_state_t       state, state_next;
    logic [3:0]        bit_cnt, bit_cnt_next;
    logic [15:0]       shreg, shreg_next;
    logic [15:0]       txreg, txreg_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [WORD_W-1:0] wdata, wdata_next;
    logic              we, we_next;
    logic              dout, dout_next;
    logic              oe, oe_next;
    logic [REL_W-1:0]  rel_cnt;

    logic [15:0]         frame;
    logic [CMD_BITS-1:0] cmd;

    // Incoming bits enter at the MSB so LSB-first data lands in natural order.
    assign frame = {data_sync, shreg[15:1]};
    assign cmd   = {data_sync, shreg[15:11]};

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            txreg   <= '0;
            addr    <= '0;
            wdata   <= '0;
            we      <= 1'b0;
            dout    <= 1'b0;
            oe      <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            txreg   <= txreg_next;
            addr    <= addr_next;
            wdata   <= wdata_next;
            we      <= we_next;
            dout    <= dout_next;
            oe      <= oe_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        txreg_next   = txreg;
        addr_next    = addr;
        wdata_next   = wdata;
        we_next      = 1'b0;
        dout_next    = dout;
        oe_next      = oe;

        if (!pe_sync) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            oe_next      = 1'b0;
            dout_next    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pe_rise) begin
                        addr_next    = '0;
                        bit_cnt_next = '0;
                        state_next   = CMD;
                    end
                end
                CMD: begin
                    if (ck_fall) begin
                        shreg_next = frame;
                        if (bit_cnt == 4'(CMD_BITS - 1)) begin
                            bit_cnt_next = '0;
                            case (cmd)
                                CMD_LOAD: state_next = RX;
                                CMD_READ: begin
                                    state_next = TX;
                                    txreg_next = {1'b0, mem.rdata, 1'b0};
                                    oe_next    = 1'b1;
                                end
                                CMD_INC:  addr_next  = addr + 1'b1;
                                CMD_PROG: state_next = WR;
                                CMD_RSTA: addr_next  = '0;
                                default:  ;
                            endcase
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                RX: begin
                    if (ck_fall) begin
                        shreg_next = frame;
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            wdata_next   = frame[WORD_W:1];
                            bit_cnt_next = '0;
                            state_next   = CMD;
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                TX: begin
                    if (ck_rise) begin
                        dout_next  = txreg[0];
                        txreg_next = {1'b0, txreg[15:1]};
                    end
                    if (ck_fall) begin
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            oe_next      = 1'b0;
                            dout_next    = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = CMD;
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                WR: begin
                    we_next    = 1'b1;
                    state_next = CMD;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Counter sits at RELEASE_CYC while programming and drains once prog_en
    // drops; the reset value of 1 stretches core_rst one cycle past rst_ext.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            rel_cnt <= REL_W'(1);
        end else if (pe_sync) begin
            rel_cnt <= REL_W'(RELEASE_CYC);
        end else if (rel_cnt != '0) begin
            rel_cnt <= rel_cnt - 1'b1;
        end
    end

    assign core_rst      = rst_ext | pe_sync | (rel_cnt != '0);
    assign icsp_data_out = dout;
    assign icsp_data_oe  = oe;
    assign mem.addr      = addr;
    assign mem.wdata     = wdata;
    assign mem.we        = we;

endmodule

// File: tb/tb_pic_icsp_loader.sv
// Scoreboard bench for pic_icsp_loader: host-side serial driver, progmem
// model, and a write monitor checking each mem_we pulse against a queue.
module tb_pic_icsp_loader;
    import pic_icsp_pkg::*;

    // Narrow address so the wrap test needs only 2**6 INC commands.
    localparam int ADDR_W      = 6;
    localparam int RELEASE_CYC = 4;
    localparam int HALF        = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ext, prog_en, icsp_clk, icsp_data_in;
    logic icsp_data_out, icsp_data_oe, core_rst;

    pic_icsp_loader_if #(.ADDR_W(ADDR_W)) mem ();

    pic_icsp_loader #(.ADDR_W(ADDR_W), .RELEASE_CYC(RELEASE_CYC)) dut (
        .clk           (clk),
        .rst_ext       (rst_ext),
        .prog_en       (prog_en),
        .icsp_clk      (icsp_clk),
        .icsp_data_in  (icsp_data_in),
        .icsp_data_out (icsp_data_out),
        .icsp_data_oe  (icsp_data_oe),
        .core_rst      (core_rst),
        .mem           (mem)
    );

    logic [WORD_W-1:0] progmem [0:(2**ADDR_W)-1];
    assign mem.rdata = progmem[mem.addr];
    always @(posedge clk) if (mem.we === 1'b1) progmem[mem.addr] <= mem.wdata;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests_run    = 0;
    int  tests_failed = 0;
    int  wr_count     = 0;
    int  core_rst_bad = 0;
    bit  hold_check   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem.we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected none",
                         mem.addr, mem.wdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write addr", 32'(mem.addr), 32'(e.addr));
                checkOutput("write data", 32'(mem.wdata), 32'(e.data));
            end
        end
        if (hold_check && core_rst !== 1'b1) core_rst_bad++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        icsp_data_in = b;
        icsp_clk     = 1'b1;
        waitCycles(HALF);
        icsp_clk     = 1'b0;
        waitCycles(HALF);
    endtask

    task automatic sendCmd(input logic [5:0] c);
        for (int i = 0; i < CMD_BITS; i++) sendBit(c[i]);
    endtask

    task automatic sendWord(input logic [13:0] w);
        logic [15:0] f;
        f = {1'b0, w, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) sendBit(f[i]);
    endtask

    task automatic applyStimulus(input logic [5:0] c, input logic [13:0] w);
        sendCmd(c);
        if (c == CMD_LOAD) sendWord(w);
    endtask

    task automatic readWord(output logic [15:0] f, output int oe_low);
        oe_low = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            icsp_clk = 1'b1;
            waitCycles(HALF);
            f[i] = icsp_data_out;
            if (icsp_data_oe !== 1'b1) oe_low++;
            icsp_clk = 1'b0;
            waitCycles(HALF);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        int          oe_low;
        int          n;
        logic [15:0] abort_frame;

        for (int i = 0; i < 2**ADDR_W; i++) progmem[i] = '0;
        rst_ext      = 1'b1;
        prog_en      = 1'b0;
        icsp_clk     = 1'b0;
        icsp_data_in = 1'b0;
        waitCycles(5);

        checkOutput("reset core_rst", 32'(core_rst), 32'd1);
        checkOutput("reset mem_we", 32'(mem.we), 32'd0);
        checkOutput("reset mem_addr", 32'(mem.addr), 32'd0);
        checkOutput("reset mem_wdata", 32'(mem.wdata), 32'd0);
        checkOutput("reset data_out", 32'(icsp_data_out), 32'd0);
        checkOutput("reset data_oe", 32'(icsp_data_oe), 32'd0);

        rst_ext = 1'b0;
        #1;
        checkOutput("core_rst held after rst_ext", 32'(core_rst), 32'd1);
        @(negedge clk);
        checkOutput("core_rst released", 32'(core_rst), 32'd0);
        waitCycles(20);
        checkOutput("idle no writes", 32'(wr_count), 32'd0);

        prog_en = 1'b1;
        waitCycles(8);
        hold_check = 1'b1;
        checkOutput("prog core_rst", 32'(core_rst), 32'd1);
        checkOutput("prog entry addr", 32'(mem.addr), 32'd0);

        applyStimulus(CMD_LOAD, 14'h2A5F);
        exp_q.push_back('{addr: ADDR_W'(0), data: 14'h2A5F});
        applyStimulus(CMD_PROG, 14'h0);
        applyStimulus(CMD_INC, 14'h0);
        applyStimulus(CMD_LOAD, 14'h0001);
        exp_q.push_back('{addr: ADDR_W'(1), data: 14'h0001});
        applyStimulus(CMD_PROG, 14'h0);
        waitCycles(4);
        checkOutput("program write count", 32'(wr_count), 32'd2);
        checkOutput("program addr no autoinc", 32'(mem.addr), 32'd1);

        applyStimulus(CMD_RSTA, 14'h0);
        checkOutput("rsta addr", 32'(mem.addr), 32'd0);
        checkOutput("oe low before read", 32'(icsp_data_oe), 32'd0);
        sendCmd(CMD_READ);
        readWord(rd, oe_low);
        checkOutput("read word", 32'(rd[14:1]), 32'h2A5F);
        checkOutput("read start bit", 32'(rd[0]), 32'd0);
        checkOutput("read stop bit", 32'(rd[15]), 32'd0);
        checkOutput("oe during frame", 32'(oe_low), 32'd0);
        waitCycles(4);
        checkOutput("oe low after read", 32'(icsp_data_oe), 32'd0);

        applyStimulus(CMD_RSTA, 14'h0);
        for (int i = 0; i < 2**ADDR_W; i++) applyStimulus(CMD_INC, 14'h0);
        checkOutput("addr wrap to 0", 32'(mem.addr), 32'd0);
        applyStimulus(CMD_INC, 14'h0);
        checkOutput("addr after wrap", 32'(mem.addr), 32'd1);

        sendCmd(CMD_LOAD);
        abort_frame = {1'b0, 14'h1555, 1'b0};
        for (int i = 0; i < 7; i++) sendBit(abort_frame[i]);
        hold_check = 1'b0;
        prog_en    = 1'b0;
        n = 1;
        while (n <= 50) begin
            @(negedge clk);
            if (core_rst === 1'b0) break;
            n++;
        end
        checkOutput("release delay cycles", 32'(n), 32'(2 + RELEASE_CYC));
        checkOutput("abort state", 32'(dut.state), 32'(IDLE));
        checkOutput("abort oe", 32'(icsp_data_oe), 32'd0);
        checkOutput("abort addr held", 32'(mem.addr), 32'd1);
        sendCmd(CMD_PROG);
        waitCycles(4);
        checkOutput("no write when idle", 32'(wr_count), 32'd2);

        prog_en = 1'b1;
        waitCycles(8);
        hold_check = 1'b1;
        checkOutput("reentry addr", 32'(mem.addr), 32'd0);

        applyStimulus(CMD_INC, 14'h0);
        exp_q.push_back('{addr: ADDR_W'(1), data: 14'h0001});
        applyStimulus(6'h3F, 14'h0);
        applyStimulus(CMD_PROG, 14'h0);
        waitCycles(4);
        checkOutput("unknown cmd addr", 32'(mem.addr), 32'd1);
        checkOutput("total writes", 32'(wr_count), 32'd3);

        hold_check = 1'b0;
        checkOutput("core_rst held while programming", 32'(core_rst_bad), 32'd0);
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
